// File: rtl/div_restoring_seq.sv
// Unsigned radix-2 restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and W-bit remainder.
// Latency: out_valid rises W cycles after the accept edge (1 cycle for divide-by-zero or overflow).
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_valid && out_ready.
module div_restoring_seq #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  // W must be at least 2 so the quotient shift below has a non-empty slice.
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // Partial remainder, dividend-low/quotient shift register and captured divisor.
  logic [W-1:0]  rem_q;
  logic [W-1:0]  qreg_q;
  logic [W-1:0]  dvsr_q;
  logic [CW-1:0] count_q;

  // Error bookkeeping: an error operation spends one RUN cycle just to
  // give it the one-cycle latency, and skips the iteration entirely.
  logic          err_q;
  logic          zero_q;
  logic          ovf_q;

  logic          accept;
  logic          hi_ge;
  logic          last_step;
  logic [W:0]    trial;
  logic          q_bit;
  logic [W-1:0]  rem_nxt;
  logic [W-1:0]  qreg_nxt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign last_step = (state == RUN) && (count_q == '0);

  // The quotient only fits in W bits when the dividend's upper half is below the divisor.
  assign hi_ge = (dividend[2*W-1:W] >= divisor);

  // One restoring step: shift in the next dividend bit and try subtracting the divisor.
  always_comb begin
    trial    = {rem_q, qreg_q[W-1]};
    q_bit    = (trial >= {1'b0, dvsr_q});
    // When the subtraction succeeds the result is below the divisor, so W bits suffice.
    rem_nxt  = q_bit ? (trial[W-1:0] - dvsr_q) : trial[W-1:0];
    qreg_nxt = {qreg_q[W-2:0], q_bit};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE on the last step, DONE -> IDLE on handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (count_q == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture with error classification, then one quotient bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      qreg_q  <= '0;
      dvsr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      if (divisor == '0) begin
        // Divide by zero: saturated quotient, low half of the dividend as remainder.
        rem_q   <= dividend[W-1:0];
        qreg_q  <= '1;
        count_q <= '0;
        err_q   <= 1'b1;
        zero_q  <= 1'b1;
        ovf_q   <= 1'b0;
      end else if (hi_ge) begin
        // Quotient would need more than W bits: saturate and report zero remainder.
        rem_q   <= '0;
        qreg_q  <= '1;
        count_q <= '0;
        err_q   <= 1'b1;
        zero_q  <= 1'b0;
        ovf_q   <= 1'b1;
      end else begin
        rem_q   <= dividend[2*W-1:W];
        qreg_q  <= dividend[W-1:0];
        dvsr_q  <= divisor;
        count_q <= CW'(W - 1);
        err_q   <= 1'b0;
        zero_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end
    end else if (state == RUN && !err_q) begin
      rem_q   <= rem_nxt;
      qreg_q  <= qreg_nxt;
      count_q <= count_q - CW'(1);
    end
  end

  // Result registers: loaded once on entry to DONE so they stay stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      overflow  <= 1'b0;
    end else if (last_step) begin
      if (err_q) begin
        quotient  <= qreg_q;
        remainder <= rem_q;
      end else begin
        quotient  <= qreg_nxt;
        remainder <= rem_nxt;
      end
      div_zero <= zero_q;
      overflow <= ovf_q;
    end
  end

endmodule
